// File: rtl/pipe_reg_hazard.sv
// Pipeline-stage register with hazard hooks (stall holds, flush bubbles) and
// saturating stall/flush activity counters for debug and performance analysis.
module pipe_reg_hazard #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_DATA   = 5,
   parameter int CTRL_WIDTH = 16,
   parameter int RD_WIDTH   = 5,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall_i,
   input  logic                           flush_i,
   input  logic                           valid_i,
   input  logic [CTRL_WIDTH-1:0]          ctrl_i,
   input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
   input  logic [RD_WIDTH-1:0]            rd_i,
   output logic                           valid_o,
   output logic [CTRL_WIDTH-1:0]          ctrl_o,
   output logic [NUM_DATA*DATA_WIDTH-1:0] data_o,
   output logic [RD_WIDTH-1:0]            rd_o,
   output logic [CNT_WIDTH-1:0]           stall_cnt_o,
   output logic [CNT_WIDTH-1:0]           flush_cnt_o,
   output logic [CNT_WIDTH-1:0]           stall_run_o
);

   logic                           r_valid;
   logic [CTRL_WIDTH-1:0]          r_ctrl;
   logic [NUM_DATA*DATA_WIDTH-1:0] r_data;
   logic [RD_WIDTH-1:0]            r_rd;
   logic [CNT_WIDTH-1:0]           r_stall_cnt;
   logic [CNT_WIDTH-1:0]           r_flush_cnt;
   logic [CNT_WIDTH-1:0]           r_stall_run;

   logic w_stall_cnt_max;
   logic w_flush_cnt_max;
   logic w_stall_run_max;

   assign w_stall_cnt_max = &r_stall_cnt;
   assign w_flush_cnt_max = &r_flush_cnt;
   assign w_stall_run_max = &r_stall_run;

   // Priority: rst > flush > stall > load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_ctrl      <= '0;
         r_data      <= '0;
         r_rd        <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_stall_run <= '0;
      end else if (flush_i) begin
         r_valid     <= 1'b0;
         r_ctrl      <= '0;
         r_data      <= '0;
         r_rd        <= '0;
         r_stall_run <= '0;
         if (!w_flush_cnt_max) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else if (stall_i) begin
         if (!w_stall_cnt_max) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (!w_stall_run_max) r_stall_run <= r_stall_run + 1'b1;
      end else begin
         r_valid     <= valid_i;
         // An invalid slot must never carry RegWrite/MemWrite downstream.
         r_ctrl      <= valid_i ? ctrl_i : '0;
         r_data      <= data_i;
         r_rd        <= rd_i;
         r_stall_run <= '0;
      end
   end

   assign valid_o     = r_valid;
   assign ctrl_o      = r_ctrl;
   assign data_o      = r_data;
   assign rd_o        = r_rd;
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
   assign stall_run_o = r_stall_run;

endmodule

// File: tb/tb_pipe_reg_hazard.sv
// Scoreboard bench for pipe_reg_hazard: stimulus pushes the expected stage
// contents, a monitor compares them one edge later.
module tb_pipe_reg_hazard;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_DATA   = 5;
   localparam int CTRL_WIDTH = 16;
   localparam int RD_WIDTH   = 5;
   localparam int CNT_WIDTH  = 4;
   localparam int DW         = NUM_DATA * DATA_WIDTH;
   localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

   typedef struct {
      logic            valid;
      logic [15:0]     ctrl;
      logic [DW-1:0]   data;
      logic [4:0]      rd;
      int              scnt;
      int              fcnt;
      int              run;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  stall_i = 1'b0;
   logic                  flush_i = 1'b0;
   logic                  valid_i = 1'b0;
   logic [CTRL_WIDTH-1:0] ctrl_i = '0;
   logic [DW-1:0]         data_i = '0;
   logic [RD_WIDTH-1:0]   rd_i = '0;
   logic                  valid_o;
   logic [CTRL_WIDTH-1:0] ctrl_o;
   logic [DW-1:0]         data_o;
   logic [RD_WIDTH-1:0]   rd_o;
   logic [CNT_WIDTH-1:0]  stall_cnt_o;
   logic [CNT_WIDTH-1:0]  flush_cnt_o;
   logic [CNT_WIDTH-1:0]  stall_run_o;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t m;

   pipe_reg_hazard #(
      .DATA_WIDTH(DATA_WIDTH), .NUM_DATA(NUM_DATA), .CTRL_WIDTH(CTRL_WIDTH),
      .RD_WIDTH(RD_WIDTH), .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
      .valid_o(valid_o), .ctrl_o(ctrl_o), .data_o(data_o), .rd_o(rd_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .stall_run_o(stall_run_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the stage presents a result every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("valid", DW'(valid_o), DW'(e.valid));
            check("ctrl", DW'(ctrl_o), DW'(e.ctrl));
            check("data", data_o, e.data);
            check("rd", DW'(rd_o), DW'(e.rd));
            check("stall_cnt", DW'(stall_cnt_o), DW'(e.scnt));
            check("flush_cnt", DW'(flush_cnt_o), DW'(e.fcnt));
            check("stall_run", DW'(stall_run_o), DW'(e.run));
         end
      end
   end

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int k = 0; k < NUM_DATA; k++) d[k*DATA_WIDTH +: DATA_WIDTH] = $urandom;
      return d;
   endfunction

   // Reference: what the stage should hold after this edge, by the rules.
   task automatic drive(input bit r, input bit s, input bit f, input bit v,
                        input logic [15:0] c, input logic [DW-1:0] d, input logic [4:0] rdx);
      @(negedge clk);
      rst = r; stall_i = s; flush_i = f; valid_i = v; ctrl_i = c; data_i = d; rd_i = rdx;
      if (r) begin
         m.valid = 0; m.ctrl = 0; m.data = 0; m.rd = 0; m.scnt = 0; m.fcnt = 0; m.run = 0;
      end else if (f) begin
         m.valid = 0; m.ctrl = 0; m.data = 0; m.rd = 0; m.run = 0;
         m.fcnt = (m.fcnt + 1 > CNT_MAX) ? CNT_MAX : m.fcnt + 1;
      end else if (s) begin
         m.scnt = (m.scnt + 1 > CNT_MAX) ? CNT_MAX : m.scnt + 1;
         m.run  = (m.run + 1 > CNT_MAX) ? CNT_MAX : m.run + 1;
      end else begin
         m.valid = v; m.ctrl = v ? c : 16'h0; m.data = d; m.rd = rdx; m.run = 0;
      end
      sb.push_back(m);
   endtask

   task automatic rnd(input bit r, input bit s, input bit f);
      drive(r, s, f, 1'($urandom), 16'($urandom), rand_data(), 5'($urandom));
   endtask

   initial begin
      logic [DW-1:0] d0;
      int            guard;
      m = '{valid: 0, ctrl: 0, data: 0, rd: 0, scnt: 0, fcnt: 0, run: 0};
      rnd(1, 0, 0);
      rnd(1, 1, 1);
      d0 = rand_data();
      d0[31:0] = 32'hDEADBEEF;
      drive(0, 0, 0, 1, 16'hA5A5, d0, 5'd7);
      repeat (3) rnd(0, 1, 0);
      rnd(0, 0, 0);
      rnd(0, 1, 1);
      drive(0, 0, 0, 0, 16'hFFFF, rand_data(), 5'd19);
      repeat (20) rnd(0, 1, 0);
      rnd(0, 0, 0);
      repeat (4) rnd(0, 1, 0);
      rnd(1, 1, 0);
      rnd(0, 0, 0);
      rnd(0, 0, 1);
      rnd(1, 0, 1);
      for (int i = 0; i < 400; i++)
         rnd(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0));
      // Long flush burst to reach flush counter saturation.
      repeat (18) rnd(0, $urandom_range(0, 1) == 1, 1);
      rnd(0, 0, 0);
      @(negedge clk);
      rst = 0; stall_i = 0; flush_i = 0;
      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_reg_hazard.md
Name: pipe_reg_hazard

Overview:
- Parametrised pipeline-stage register: the successor to the fixed Decode->Execute register.
- Carries a packed control bundle, N data channels, the destination register index and a valid bit across one stage boundary.
- Adds hazard-unit hooks: stall (hold) and flush (bubble insertion).
- Adds performance/debug counters, so the same block is instantiated at the F/D, D/E, E/M and M/W boundaries of the pipelined RISC-V core.

Parameters:
- DATA_WIDTH, 32, width of each data channel (RD1, RD2, PC, ImmExt, PCPlus4, ...).
- NUM_DATA, 5, number of data channels packed into data_i/data_o.
- CTRL_WIDTH, 16, width of the packed control bundle (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, ...).
- RD_WIDTH, 5, destination register index width.
- CNT_WIDTH, 8, width of each counter output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold stage contents (from hazard unit).
- flush_i  input  1  replace stage contents with a bubble (from hazard unit).
- valid_i  input  1  upstream instruction is valid.
- ctrl_i  input  CTRL_WIDTH  packed control signals, stage D side.
- data_i  input  NUM_DATA*DATA_WIDTH  packed data channels; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_i  input  RD_WIDTH  destination register index.
- valid_o  output  1  registered valid.
- ctrl_o  output  CTRL_WIDTH  registered control, zero whenever valid_o=0.
- data_o  output  NUM_DATA*DATA_WIDTH  registered data channels.
- rd_o  output  RD_WIDTH  registered destination index.
- stall_cnt_o  output  CNT_WIDTH  total stall cycles since reset, saturating.
- flush_cnt_o  output  CNT_WIDTH  total flush cycles since reset, saturating.
- stall_run_o  output  CNT_WIDTH  length of the current consecutive stall run, saturating.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. When rst=1 at an edge, all outputs go to 0: valid_o, ctrl_o, data_o, rd_o and all three counters.
- Latency: 1 cycle from input to output on a load; no combinational path from any input to any output.
- Per-edge priority is rst > flush_i > stall_i > load.
- Flush (flush_i=1, regardless of stall_i):
  - valid_o<=0, ctrl_o<=0, rd_o<=0, data_o<=0.
  - flush_cnt_o increments (saturating).
  - stall_run_o<=0.
  - stall_cnt_o is unchanged.
- Stall (stall_i=1, flush_i=0):
  - valid_o, ctrl_o, data_o and rd_o hold their values.
  - stall_cnt_o and stall_run_o increment (saturating).
- Load (stall_i=0, flush_i=0):
  - valid_o<=valid_i; data_o<=data_i; rd_o<=rd_i.
  - ctrl_o<=valid_i ? ctrl_i : 0. An invalid upstream slot always becomes a control-silent bubble, so no RegWrite or MemWrite leaks through.
  - stall_run_o<=0.
- Saturation: each counter sticks at 2^CNT_WIDTH-1 and never wraps. Only rst clears stall_cnt_o and flush_cnt_o.
- A stall held across many cycles keeps the outputs bit-identical for the whole run.
- Releasing the stall loads on the first edge with stall_i=0.
- Reset asserted mid-stall or mid-flush takes effect at that edge; the input pattern from the preceding cycle has no effect.
- No X propagation: every output has a defined value from the first post-reset cycle.
- The packing order of ctrl_i and data_i is fixed by the instantiating stage; this block treats both as opaque bit vectors.

Test Plan:
- Reset then load: assert rst for 2 cycles, deassert; drive valid_i=1, ctrl_i=16'hA5A5, rd_i=5'd7, channel0=32'hDEADBEEF. Required: after rst, all outputs are 0; one edge after the load, valid_o=1, ctrl_o=16'hA5A5, rd_o=7, channel0 of data_o=32'hDEADBEEF.
- Stall hold: with the stage loaded as above, hold stall_i=1 for 3 cycles while changing all inputs. Required: outputs unchanged for all 3 cycles, stall_cnt_o=3, stall_run_o=3. On release, new inputs appear after 1 edge and stall_run_o=0.
- Flush beats stall: drive stall_i=1 and flush_i=1 together in one cycle. Required: valid_o=0, ctrl_o=0, rd_o=0, data_o=0, flush_cnt_o increments by 1, stall_cnt_o unchanged.
- Invalid upstream: load with valid_i=0 and ctrl_i=16'hFFFF. Required: valid_o=0, ctrl_o=0; data_o and rd_o still capture their inputs.
- Saturation (CNT_WIDTH=4): hold stall_i=1 for 20 cycles. Required: stall_cnt_o and stall_run_o both reach 15 and stay at 15.
- Reset mid-stall: assert rst during a stall run. Required: all outputs and counters are 0 at the next edge.
